// File: rtl/ex_pipeline_hazard_unit_if.sv
// Signal bundle between decode/ALU and the ID/EX + EX/MEM pipeline-control block.
// The hazard unit is the slave side; decode, regfile and ALU form the master side.
interface ex_pipeline_hazard_unit_if #(
    parameter int DWIDTH = 32
);
    logic [DWIDTH-1:0] id_pc;
    logic [25:0]       id_jump_addr;
    logic [3:0]        id_op;
    logic [DWIDTH-1:0] id_imm;
    logic [DWIDTH-1:0] id_rs1;
    logic [DWIDTH-1:0] id_rs2;
    logic [4:0]        id_rs1_id;
    logic [4:0]        id_rs2_id;
    logic [4:0]        id_rdst_id;
    logic              id_we_reg;
    logic              id_we_dmem;
    logic              id_ssel;
    logic [1:0]        id_wbsel;
    logic [2:0]        id_jump_type;
    logic [DWIDTH-1:0] ex_alu_out;
    logic              ex_zero;

    logic [DWIDTH-1:0] ex_pc;
    logic [DWIDTH-1:0] ex_imm;
    logic [DWIDTH-1:0] ex_rs1;
    logic [DWIDTH-1:0] ex_rs2;
    logic [25:0]       ex_jump_addr;
    logic [3:0]        ex_op;
    logic [4:0]        ex_rdst_id;
    logic              ex_we_reg;
    logic              ex_we_dmem;
    logic              ex_ssel;
    logic [1:0]        ex_wbsel;
    logic [2:0]        ex_jump_type;

    logic [DWIDTH-1:0] mem_pc;
    logic [DWIDTH-1:0] mem_rd;
    logic [DWIDTH-1:0] mem_rs2;
    logic [4:0]        mem_rdst_id;
    logic              mem_we_reg;
    logic              mem_we_dmem;
    logic [1:0]        mem_wbsel;

    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              redirect;
    logic [DWIDTH-1:0] redirect_pc;

    modport slave (
        input  id_pc, id_jump_addr, id_op, id_imm, id_rs1, id_rs2,
               id_rs1_id, id_rs2_id, id_rdst_id, id_we_reg, id_we_dmem,
               id_ssel, id_wbsel, id_jump_type, ex_alu_out, ex_zero,
        output ex_pc, ex_imm, ex_rs1, ex_rs2, ex_jump_addr, ex_op,
               ex_rdst_id, ex_we_reg, ex_we_dmem, ex_ssel, ex_wbsel,
               ex_jump_type, mem_pc, mem_rd, mem_rs2, mem_rdst_id,
               mem_we_reg, mem_we_dmem, mem_wbsel, pc_write, ifid_write,
               ifid_flush, redirect, redirect_pc
    );

    modport master (
        output id_pc, id_jump_addr, id_op, id_imm, id_rs1, id_rs2,
               id_rs1_id, id_rs2_id, id_rdst_id, id_we_reg, id_we_dmem,
               id_ssel, id_wbsel, id_jump_type, ex_alu_out, ex_zero,
        input  ex_pc, ex_imm, ex_rs1, ex_rs2, ex_jump_addr, ex_op,
               ex_rdst_id, ex_we_reg, ex_we_dmem, ex_ssel, ex_wbsel,
               ex_jump_type, mem_pc, mem_rd, mem_rs2, mem_rdst_id,
               mem_we_reg, mem_we_dmem, mem_wbsel, pc_write, ifid_write,
               ifid_flush, redirect, redirect_pc
    );
endinterface

// File: rtl/ex_pipeline_hazard_unit.sv
// ID/EX and EX/MEM pipeline registers plus RAW stall detection and EX-stage
// control-transfer redirect for a 5-stage core without forwarding.
module ex_pipeline_hazard_unit #(
    parameter int DWIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    ex_pipeline_hazard_unit_if.slave bus
);

    typedef enum logic [2:0] {
        JT_NOP = 3'd0,
        JT_BEQ = 3'd1,
        JT_JAL = 3'd2,
        JT_JR  = 3'd3,
        JT_J   = 3'd4
    } jump_type_e;

    typedef struct packed {
        logic [DWIDTH-1:0] pc;
        logic [25:0]       jump_addr;
        logic [3:0]        op;
        logic [DWIDTH-1:0] imm;
        logic [DWIDTH-1:0] rs1;
        logic [DWIDTH-1:0] rs2;
        logic [4:0]        rdst_id;
        logic              we_reg;
        logic              we_dmem;
        logic              ssel;
        logic [1:0]        wbsel;
        logic [2:0]        jump_type;
    } idex_t;

    typedef struct packed {
        logic [DWIDTH-1:0] pc;
        logic [DWIDTH-1:0] rd;
        logic [DWIDTH-1:0] rs2;
        logic [4:0]        rdst_id;
        logic              we_reg;
        logic              we_dmem;
        logic [1:0]        wbsel;
    } exmem_t;

    idex_t  idex_q,  idex_d;
    exmem_t exmem_q, exmem_d;

    logic              redirect;
    logic              stall;
    logic [DWIDTH-1:0] pc_plus4;
    logic [DWIDTH-1:0] redirect_pc;
    logic              hit_rs1;
    logic              hit_rs2;

    assign pc_plus4 = idex_q.pc + {{(DWIDTH-3){1'b0}}, 3'd4};

    always_comb begin
        redirect    = 1'b0;
        redirect_pc = pc_plus4;
        case (idex_q.jump_type)
            JT_BEQ: begin
                if (bus.ex_zero) begin
                    redirect    = 1'b1;
                    redirect_pc = pc_plus4 + (idex_q.imm << 2);
                end
            end
            JT_JR: begin
                redirect    = 1'b1;
                redirect_pc = idex_q.rs1;
            end
            JT_JAL, JT_J: begin
                redirect    = 1'b1;
                redirect_pc = {idex_q.pc[DWIDTH-1:28], idex_q.jump_addr, 2'b00};
            end
            default: ;
        endcase
    end

    // Writeback-stage producers are not checked: the regfile writes before it reads.
    assign hit_rs1 = (bus.id_rs1_id != 5'd0) &&
                     ((idex_q.we_reg  && (idex_q.rdst_id  == bus.id_rs1_id)) ||
                      (exmem_q.we_reg && (exmem_q.rdst_id == bus.id_rs1_id)));
    assign hit_rs2 = (bus.id_rs2_id != 5'd0) &&
                     ((idex_q.we_reg  && (idex_q.rdst_id  == bus.id_rs2_id)) ||
                      (exmem_q.we_reg && (exmem_q.rdst_id == bus.id_rs2_id)));
    assign stall   = hit_rs1 || hit_rs2;

    always_comb begin
        idex_d = '0;
        if (!redirect && !stall) begin
            idex_d.pc        = bus.id_pc;
            idex_d.jump_addr = bus.id_jump_addr;
            idex_d.op        = bus.id_op;
            idex_d.imm       = bus.id_imm;
            idex_d.rs1       = bus.id_rs1;
            idex_d.rs2       = bus.id_rs2;
            idex_d.rdst_id   = bus.id_rdst_id;
            idex_d.we_reg    = bus.id_we_reg;
            idex_d.we_dmem   = bus.id_we_dmem;
            idex_d.ssel      = bus.id_ssel;
            idex_d.wbsel     = bus.id_wbsel;
            idex_d.jump_type = bus.id_jump_type;
        end
    end

    // The instruction in EX always advances, so a redirecting JAL still writes back.
    always_comb begin
        exmem_d         = '0;
        exmem_d.pc      = idex_q.pc;
        exmem_d.rd      = bus.ex_alu_out;
        exmem_d.rs2     = idex_q.rs2;
        exmem_d.rdst_id = idex_q.rdst_id;
        exmem_d.we_reg  = idex_q.we_reg;
        exmem_d.we_dmem = idex_q.we_dmem;
        exmem_d.wbsel   = idex_q.wbsel;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
        end
    end

    assign bus.ex_pc        = idex_q.pc;
    assign bus.ex_imm       = idex_q.imm;
    assign bus.ex_rs1       = idex_q.rs1;
    assign bus.ex_rs2       = idex_q.rs2;
    assign bus.ex_jump_addr = idex_q.jump_addr;
    assign bus.ex_op        = idex_q.op;
    assign bus.ex_rdst_id   = idex_q.rdst_id;
    assign bus.ex_we_reg    = idex_q.we_reg;
    assign bus.ex_we_dmem   = idex_q.we_dmem;
    assign bus.ex_ssel      = idex_q.ssel;
    assign bus.ex_wbsel     = idex_q.wbsel;
    assign bus.ex_jump_type = idex_q.jump_type;

    assign bus.mem_pc       = exmem_q.pc;
    assign bus.mem_rd       = exmem_q.rd;
    assign bus.mem_rs2      = exmem_q.rs2;
    assign bus.mem_rdst_id  = exmem_q.rdst_id;
    assign bus.mem_we_reg   = exmem_q.we_reg;
    assign bus.mem_we_dmem  = exmem_q.we_dmem;
    assign bus.mem_wbsel    = exmem_q.wbsel;

    assign bus.redirect     = redirect;
    assign bus.redirect_pc  = redirect_pc;
    assign bus.pc_write     = redirect || !stall;
    assign bus.ifid_write   = redirect || !stall;
    assign bus.ifid_flush   = redirect;

endmodule

// File: tb/tb_ex_pipeline_hazard_unit.sv
// Directed bench for ex_pipeline_hazard_unit: the driver queues hand-computed
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_ex_pipeline_hazard_unit;

    localparam int DWIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ex_pipeline_hazard_unit_if #(.DWIDTH(DWIDTH)) bus ();

    ex_pipeline_hazard_unit #(.DWIDTH(DWIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam int S_EX_PC = 0,  S_EX_RDST = 1,  S_EX_OP = 2,   S_EX_JT = 3;
    localparam int S_EX_WE = 4,  S_MEM_PC = 5,   S_MEM_RD = 6,  S_MEM_WE = 7;
    localparam int S_MEM_RDST = 8, S_MEM_WBSEL = 9, S_PCW = 10, S_IFIDW = 11;
    localparam int S_FLUSH = 12, S_REDIR = 13,   S_RPC = 14,    S_EX_IMM = 15;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            S_EX_PC:     return bus.ex_pc;
            S_EX_RDST:   return {27'd0, bus.ex_rdst_id};
            S_EX_OP:     return {28'd0, bus.ex_op};
            S_EX_JT:     return {29'd0, bus.ex_jump_type};
            S_EX_WE:     return {31'd0, bus.ex_we_reg};
            S_MEM_PC:    return bus.mem_pc;
            S_MEM_RD:    return bus.mem_rd;
            S_MEM_WE:    return {31'd0, bus.mem_we_reg};
            S_MEM_RDST:  return {27'd0, bus.mem_rdst_id};
            S_MEM_WBSEL: return {30'd0, bus.mem_wbsel};
            S_PCW:       return {31'd0, bus.pc_write};
            S_IFIDW:     return {31'd0, bus.ifid_write};
            S_FLUSH:     return {31'd0, bus.ifid_flush};
            S_REDIR:     return {31'd0, bus.redirect};
            S_RPC:       return bus.redirect_pc;
            S_EX_IMM:    return bus.ex_imm;
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = sb.pop_front();
            act = sample(e.sel);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, act, e.exp, $time);
            end
        end
    end

    task automatic expect_sig(input string n, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.sel  = sel;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic expect_ctl(input string n, input logic pcw, input logic flush, input logic redir);
        expect_sig({n, ".pc_write"},   S_PCW,   {31'd0, pcw});
        expect_sig({n, ".ifid_write"}, S_IFIDW, {31'd0, pcw});
        expect_sig({n, ".ifid_flush"}, S_FLUSH, {31'd0, flush});
        expect_sig({n, ".redirect"},   S_REDIR, {31'd0, redir});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_pc        = '0;
        bus.id_jump_addr = '0;
        bus.id_op        = '0;
        bus.id_imm       = '0;
        bus.id_rs1       = '0;
        bus.id_rs2       = '0;
        bus.id_rs1_id    = '0;
        bus.id_rs2_id    = '0;
        bus.id_rdst_id   = '0;
        bus.id_we_reg    = 1'b0;
        bus.id_we_dmem   = 1'b0;
        bus.id_ssel      = 1'b0;
        bus.id_wbsel     = '0;
        bus.id_jump_type = '0;
        bus.ex_alu_out   = '0;
        bus.ex_zero      = 1'b0;
    endtask

    task automatic load_producer(input logic [31:0] pc, input logic [4:0] rdst);
        idle();
        bus.id_pc      = pc;
        bus.id_rdst_id = rdst;
        bus.id_we_reg  = 1'b1;
    endtask

    task automatic drain();
        idle();
        tick();
        tick();
        tick();
    endtask

    initial begin
        // Reset with garbage on every input
        bus.id_pc        = 32'hFFFF_FFF0;
        bus.id_jump_addr = 26'h3FF_FFFF;
        bus.id_op        = 4'hF;
        bus.id_imm       = 32'h1234_5678;
        bus.id_rs1       = 32'hAAAA_AAAA;
        bus.id_rs2       = 32'h5555_5555;
        bus.id_rs1_id    = 5'd3;
        bus.id_rs2_id    = 5'd4;
        bus.id_rdst_id   = 5'd3;
        bus.id_we_reg    = 1'b1;
        bus.id_we_dmem   = 1'b1;
        bus.id_ssel      = 1'b1;
        bus.id_wbsel     = 2'b11;
        bus.id_jump_type = 3'd2;
        bus.ex_alu_out   = 32'hFFFF_FFFF;
        bus.ex_zero      = 1'b1;
        tick();
        tick();
        expect_sig("rst.ex_pc",  S_EX_PC,  32'h0);
        expect_sig("rst.ex_jt",  S_EX_JT,  32'h0);
        expect_sig("rst.ex_we",  S_EX_WE,  32'h0);
        expect_sig("rst.mem_pc", S_MEM_PC, 32'h0);
        expect_sig("rst.mem_we", S_MEM_WE, 32'h0);
        expect_ctl("rst", 1'b1, 1'b0, 1'b0);
        idle();
        tick();
        rst = 1'b1;

        // Pass-through
        idle();
        bus.id_pc      = 32'h100;
        bus.id_op      = 4'd3;
        bus.id_we_reg  = 1'b1;
        bus.id_rdst_id = 5'd5;
        expect_ctl("pass.id", 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        bus.ex_alu_out = 32'hABCD;
        expect_sig("pass.ex_pc",   S_EX_PC,   32'h100);
        expect_sig("pass.ex_rdst", S_EX_RDST, 32'd5);
        expect_sig("pass.ex_op",   S_EX_OP,   32'd3);
        tick();
        idle();
        expect_sig("pass.mem_pc",   S_MEM_PC,   32'h100);
        expect_sig("pass.mem_rd",   S_MEM_RD,   32'hABCD);
        expect_sig("pass.mem_we",   S_MEM_WE,   32'h1);
        expect_sig("pass.mem_rdst", S_MEM_RDST, 32'd5);
        expect_sig("pass.ex_pc2",   S_EX_PC,    32'h0);
        drain();

        // RAW on an EX-stage producer: two bubbles
        load_producer(32'h200, 5'd5);
        tick();
        idle();
        bus.id_pc     = 32'h204;
        bus.id_rs1_id = 5'd5;
        expect_ctl("raw.ex", 1'b0, 1'b0, 1'b0);
        tick();
        expect_sig("raw.bubble_we", S_EX_WE,    32'h0);
        expect_sig("raw.bubble_pc", S_EX_PC,    32'h0);
        expect_sig("raw.mem_rdst",  S_MEM_RDST, 32'd5);
        expect_ctl("raw.mem", 1'b0, 1'b0, 1'b0);
        tick();
        expect_ctl("raw.clear", 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        expect_sig("raw.consumer_pc", S_EX_PC, 32'h204);
        drain();

        // Producer writing r0 never stalls
        load_producer(32'h300, 5'd0);
        tick();
        idle();
        bus.id_pc     = 32'h304;
        bus.id_rs1_id = 5'd0;
        bus.id_rs2_id = 5'd0;
        expect_ctl("raw.r0", 1'b1, 1'b0, 1'b0);
        tick();
        drain();

        // MEM-only hit on rs2: one bubble
        load_producer(32'h400, 5'd7);
        tick();
        idle();
        bus.id_pc = 32'h404;
        tick();
        idle();
        bus.id_pc     = 32'h408;
        bus.id_rs2_id = 5'd7;
        expect_ctl("raw.memonly", 1'b0, 1'b0, 1'b0);
        tick();
        expect_ctl("raw.memonly_clr", 1'b1, 1'b0, 1'b0);
        tick();
        drain();

        // BEQ taken, with a younger instruction in ID that must be squashed
        idle();
        bus.id_pc        = 32'h40;
        bus.id_imm       = 32'd3;
        bus.id_jump_type = 3'd1;
        tick();
        idle();
        bus.ex_zero    = 1'b1;
        bus.id_pc      = 32'h44;
        bus.id_we_reg  = 1'b1;
        bus.id_rdst_id = 5'd9;
        expect_ctl("beq.t", 1'b1, 1'b1, 1'b1);
        expect_sig("beq.t.rpc", S_RPC, 32'h50);
        tick();
        idle();
        expect_sig("beq.squash_jt", S_EX_JT,  32'h0);
        expect_sig("beq.squash_pc", S_EX_PC,  32'h0);
        expect_sig("beq.squash_we", S_EX_WE,  32'h0);
        expect_sig("beq.mem_pc",    S_MEM_PC, 32'h40);
        drain();

        // BEQ not taken
        idle();
        bus.id_pc        = 32'h40;
        bus.id_imm       = 32'd3;
        bus.id_jump_type = 3'd1;
        tick();
        idle();
        expect_ctl("beq.nt", 1'b1, 1'b0, 1'b0);
        expect_sig("beq.nt.rpc", S_RPC, 32'h44);
        tick();
        drain();

        // Backward BEQ: negative offset wraps through the adder
        idle();
        bus.id_pc        = 32'h80;
        bus.id_imm       = 32'hFFFF_FFFC;
        bus.id_jump_type = 3'd1;
        tick();
        idle();
        bus.ex_zero = 1'b1;
        expect_sig("beq.back.rpc", S_RPC, 32'h74);
        tick();
        drain();

        // J
        idle();
        bus.id_pc        = 32'h1000_0040;
        bus.id_jump_addr = 26'h10;
        bus.id_jump_type = 3'd4;
        tick();
        idle();
        expect_ctl("j", 1'b1, 1'b1, 1'b1);
        expect_sig("j.rpc", S_RPC, 32'h1000_0040);
        tick();
        drain();

        // JR
        idle();
        bus.id_pc        = 32'h500;
        bus.id_rs1       = 32'h200;
        bus.id_jump_type = 3'd3;
        tick();
        idle();
        expect_sig("jr.redir", S_REDIR, 32'h1);
        expect_sig("jr.rpc",   S_RPC,   32'h200);
        tick();
        drain();

        // Undefined jump type behaves as NOP
        idle();
        bus.id_pc        = 32'h600;
        bus.id_jump_addr = 26'h55;
        bus.id_jump_type = 3'd5;
        tick();
        idle();
        expect_sig("jt5.redir", S_REDIR, 32'h0);
        expect_sig("jt5.rpc",   S_RPC,   32'h604);
        tick();
        drain();

        // JAL with a simultaneous RAW hit: redirect wins, JAL still reaches MEM
        idle();
        bus.id_pc        = 32'h300;
        bus.id_jump_addr = 26'h80;
        bus.id_jump_type = 3'd2;
        bus.id_we_reg    = 1'b1;
        bus.id_rdst_id   = 5'd31;
        bus.id_wbsel     = 2'b10;
        tick();
        idle();
        bus.id_pc      = 32'h304;
        bus.id_rs1_id  = 5'd31;
        bus.ex_alu_out = 32'h1234;
        expect_ctl("jal.raw", 1'b1, 1'b1, 1'b1);
        expect_sig("jal.rpc", S_RPC, 32'h200);
        tick();
        expect_sig("jal.bubble_pc",  S_EX_PC,     32'h0);
        expect_sig("jal.bubble_jt",  S_EX_JT,     32'h0);
        expect_sig("jal.mem_pc",     S_MEM_PC,    32'h300);
        expect_sig("jal.mem_rdst",   S_MEM_RDST,  32'd31);
        expect_sig("jal.mem_we",     S_MEM_WE,    32'h1);
        expect_sig("jal.mem_wbsel",  S_MEM_WBSEL, 32'd2);
        expect_ctl("jal.memhit", 1'b0, 1'b0, 1'b0);
        tick();
        drain();

        // Reset asserted mid-stall clears registers without a clock edge
        load_producer(32'h700, 5'd12);
        bus.id_imm = 32'h77;
        tick();
        idle();
        bus.id_rs1_id = 5'd12;
        expect_ctl("prerst.stall", 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        expect_sig("midrst.mem_we", S_MEM_WE, 32'h0);
        expect_sig("midrst.ex_imm", S_EX_IMM, 32'h0);
        expect_ctl("midrst", 1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        idle();
        tick();

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_pipeline_hazard_unit.md
Name: ex_pipeline_hazard_unit

Overview:
Combined pipeline-control block for the 5-stage 32-bit MIPS-like core. It holds the ID/EX pipeline register and the EX/MEM pipeline register. It also contains the hazard unit: RAW stall detection and control-transfer redirect/squash.
- It sits between decode/regfile and the ALU/data memory.
- It drives PC/IF-ID enables and the redirect target.

Parameters:
DWIDTH, 32, datapath width (PC, immediates, register data, ALU result).

Ports:
- clk  in  1  clock; all registers update on rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_pc  in  DWIDTH  PC of instruction in ID.
- id_jump_addr  in  26  J-format target field.
- id_op  in  4  ALU opcode.
- id_imm  in  DWIDTH  sign-extended immediate.
- id_rs1, id_rs2  in  DWIDTH  regfile read data.
- id_rs1_id, id_rs2_id  in  5  source register indices.
- id_rdst_id  in  5  destination register index.
- id_we_reg, id_we_dmem, id_ssel  in  1  each; decoded controls.
- id_wbsel  in  2  writeback select: 00 ALU, 01 dmem, 10 PC+4.
- id_jump_type  in  3  NOP=0, BEQ=1, JAL=2, JR=3, J=4; 5-7 treated as NOP.
- ex_alu_out  in  DWIDTH  ALU result for the instruction in EX.
- ex_zero  in  1  ALU zero flag.
- ex_pc, ex_imm, ex_rs1, ex_rs2  out  DWIDTH  registered ID/EX fields.
- ex_jump_addr  out  26  registered ID/EX field.
- ex_op  out  4  registered ID/EX field.
- ex_rdst_id  out  5  registered ID/EX field.
- ex_we_reg, ex_we_dmem, ex_ssel  out  1  registered ID/EX fields.
- ex_wbsel  out  2  registered ID/EX field.
- ex_jump_type  out  3  registered ID/EX field.
- mem_pc, mem_rd, mem_rs2  out  DWIDTH  registered EX/MEM fields.
- mem_rdst_id  out  5  registered EX/MEM field.
- mem_we_reg, mem_we_dmem  out  1  registered EX/MEM fields.
- mem_wbsel  out  2  registered EX/MEM field.
- pc_write, ifid_write  out  1  PC and IF/ID load enables.
- ifid_flush  out  1  clear IF/ID to NOP next edge.
- redirect  out  1  control transfer taken in EX.
- redirect_pc  out  DWIDTH  next-PC when redirect=1.

Behaviour:
- Reset (rst=0, asynchronous): every ID/EX and EX/MEM register is cleared to 0. This is a bubble: jump_type NOP, no writes.
  - Combinational outputs during reset: redirect=0, pc_write=1, ifid_write=1, ifid_flush=0.
- Latency: one cycle per stage. ID inputs appear on ex_* after one edge; EX values appear on mem_* after one edge.
- EX/MEM capture: never stalls or flushes.
  - mem_pc<=ex_pc, mem_rd<=ex_alu_out, mem_rs2<=ex_rs2.
  - Controls copied from ex_* fields.
- Redirect (combinational from EX fields):
  - BEQ with ex_zero=1 → redirect; redirect_pc = ex_pc+4+(ex_imm<<2), mod 2^32.
  - JR → redirect; redirect_pc = ex_rs1.
  - JAL or J → redirect; redirect_pc = {ex_pc[31:28], ex_jump_addr, 2'b00}.
  - Otherwise redirect=0 and redirect_pc=ex_pc+4.
- RAW stall (combinational):
  - Define hit(r) = r≠0 and ((ex_we_reg and ex_rdst_id=r) or (mem_we_reg and mem_rdst_id=r)).
  - stall = hit(id_rs1_id) or hit(id_rs2_id).
  - There is no forwarding; the writeback-stage hazard is resolved by the register file (write-before-read).
- Priority: redirect overrides stall.
  - redirect=1: pc_write=1, ifid_write=1, ifid_flush=1; ID/EX loads a bubble. The instruction in EX itself proceeds to EX/MEM normally, so JAL writes back.
  - stall=1 and redirect=0: pc_write=0, ifid_write=0, ifid_flush=0; ID/EX loads a bubble.
  - Neither: pc_write=1, ifid_write=1, ifid_flush=0; ID/EX loads the id_* inputs.
- Bubble definition: all ID/EX fields cleared to 0.
- Stall resolution: a stall releases automatically as the producer drains past MEM. This takes at most 2 bubbles for an EX hit and 1 for a MEM-only hit.
- Reset asserted mid-stall or mid-redirect clears everything immediately. No state survives reset.

Test Plan:
- Reset: drive rst=0 with garbage id_* → all ex_*/mem_* = 0; pc_write=1, ifid_write=1, ifid_flush=0, redirect=0.
- Pass-through: id_pc=0x100, id_op=3, id_we_reg=1, id_rdst_id=5, ex_alu_out=0xABCD, no hazards → after one edge ex_pc=0x100, ex_rdst_id=5; after the second edge mem_pc=0x100, mem_rd=0xABCD, mem_we_reg=1.
- RAW stall: producer with rdst=5, we_reg=1 in EX; ID has rs1_id=5 → pc_write=0, ifid_write=0, ID/EX loads bubble. Stall persists while the producer is in MEM and clears once it leaves MEM (2 bubbles total). A producer with rdst=0 causes no stall.
- BEQ taken: ex_jump_type=1, ex_pc=0x40, ex_imm=3, ex_zero=1 → redirect=1, redirect_pc=0x50, ifid_flush=1, next ex_jump_type=0. With ex_zero=0 → redirect=0, redirect_pc=0x44.
- Jumps: J with ex_pc=0x1000_0040, ex_jump_addr=0x10 → redirect_pc=0x1000_0040. JR with ex_rs1=0x200 → redirect_pc=0x200.
- Redirect plus simultaneous RAW hit → pc_write=1, ifid_write=1, ifid_flush=1, ID/EX bubble; EX/MEM still captures the jump's fields.
